// File: rtl/mem_io_bridge.sv
// mem_io_bridge: byte-wide CPU bus bridge to 128KB RAM and a memory-mapped
// I/O window (a[17:16]==2'b11). Provides one-cycle read return, a UART TX
// FIFO, RX byte pop, a free-running cycle counter with byte snapshot, and a
// program-stop handshake that drains a 0x00 terminator before stopping.
// Ports:
//   clk_in, rst_in          clock, async active-low reset
//   rdy_in                  cpu ready; gates counter and cpu-side side effects
//   cpu_a/cpu_dout/cpu_wr   cpu access; cpu_din returns read data next cycle
//   io_buffer_full          TX FIFO near full (registered)
//   ram_a/ram_dout/ram_we   RAM request (combinational); ram_din one cycle later
//   rx_data/rx_valid/rx_pop UART RX byte and its pop strobe
//   tx_data/tx_valid/tx_ready UART TX FIFO head handshake
//   program_stop            sticky, set once the terminator has drained
module mem_io_bridge #(
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned FULL_MARGIN = 2,
  parameter int unsigned RAM_AW      = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [31:0]       cpu_a,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_din,
  output logic              io_buffer_full,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_we,
  input  logic [7:0]        ram_din,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              program_stop
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_STOPPED} state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_RX, SRC_SNAP} src_t;

  state_t        state, state_nx;
  src_t          rd_src, rd_src_nx;
  logic [1:0]    rd_byte;
  logic [7:0]    rx_hold;
  logic [31:0]   cycle_cnt;
  logic [31:0]   snapshot;

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free_cnt;
  logic          fifo_full;
  logic          push, pop;
  logic [7:0]    push_data;

  logic          io_sel, io_wr;
  logic          is_data, is_ctl, is_snap;
  logic [15:0]   off;
  logic          unused_addr;

  // Address decode
  assign io_sel  = (cpu_a[17:16] == 2'b11);
  assign off     = cpu_a[15:0];
  assign is_data = (off == 16'h0000);
  assign is_ctl  = (off == 16'h0004);
  assign is_snap = (off[15:2] == 14'h0001);
  assign io_wr   = cpu_wr & io_sel & rdy_in;
  assign unused_addr = ^cpu_a[31:18];

  // RAM request path
  assign ram_a    = cpu_a[RAM_AW-1:0];
  assign ram_dout = cpu_dout;
  assign ram_we   = cpu_wr & ~io_sel & rdy_in;

  // RX pop and counter snapshot happen in the access cycle
  assign rx_pop = ~cpu_wr & io_sel & is_data & rx_valid & rdy_in;

  // TX FIFO status
  assign fifo_full = (count == CW'(TX_DEPTH));
  assign free_cnt  = CW'(TX_DEPTH) - count;
  assign tx_valid  = (count != '0);
  assign tx_data   = fifo_mem[rd_ptr];
  assign pop       = tx_valid & tx_ready;

  // Next-state and FIFO push decision; the terminator bypasses the zero filter
  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    push_data = cpu_dout;
    case (state)
      S_RUN: begin
        if (io_wr && is_data && (cpu_dout != 8'h00) && !fifo_full) begin
          push = 1'b1;
        end else if (io_wr && is_ctl && !fifo_full) begin
          push      = 1'b1;
          push_data = 8'h00;
          state_nx  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Terminator was the last entry, so empty means it was accepted
        if (count == '0) state_nx = S_STOPPED;
      end
      S_STOPPED: state_nx = S_STOPPED;
      default:   state_nx = S_RUN;
    endcase
  end

  // Source of next cycle's read data
  always_comb begin
    rd_src_nx = SRC_ZERO;
    if (!cpu_wr) begin
      if (!io_sel)      rd_src_nx = SRC_RAM;
      else if (is_data) rd_src_nx = rx_pop ? SRC_RX : SRC_ZERO;
      else if (is_snap) rd_src_nx = SRC_SNAP;
      else              rd_src_nx = SRC_ZERO;
    end
  end

  // Read data mux, one cycle after the access
  always_comb begin
    cpu_din = 8'h00;
    case (rd_src)
      SRC_RAM: cpu_din = ram_din;
      SRC_RX:  cpu_din = rx_hold;
      SRC_SNAP: begin
        case (rd_byte)
          2'd0:    cpu_din = snapshot[7:0];
          2'd1:    cpu_din = snapshot[15:8];
          2'd2:    cpu_din = snapshot[23:16];
          default: cpu_din = snapshot[31:24];
        endcase
      end
      default: cpu_din = 8'h00;
    endcase
  end

  // FSM state and sticky stop flag
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= S_RUN;
      program_stop <= 1'b0;
    end else begin
      state        <= state_nx;
      program_stop <= (state_nx == S_STOPPED);
    end
  end

  // Read-return registers, counter and snapshot
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_src    <= SRC_ZERO;
      rd_byte   <= 2'd0;
      rx_hold   <= 8'h00;
      cycle_cnt <= 32'd0;
      snapshot  <= 32'd0;
    end else begin
      rd_src  <= rd_src_nx;
      rd_byte <= off[1:0];
      if (rx_pop) rx_hold <= rx_data;
      if (~cpu_wr & io_sel & is_ctl & rdy_in) snapshot <= cycle_cnt;
      if (rdy_in) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  // TX FIFO pointers, occupancy and near-full flag
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      io_buffer_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      io_buffer_full <= (free_cnt <= CW'(FULL_MARGIN));
    end
  end

endmodule
